// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Lets N_REQ requesters share one uart_tx transmitter. A one-cycle request
// pulse latches that requester's byte into its own slot and marks the slot
// pending. A round-robin FSM hands the pending bytes to uart_tx one at a time
// using a tx_start / tx_busy handshake.
//
// Ports
//   clk        system clock; all logic runs on the rising edge
//   rst_n      asynchronous active-low reset with synchronous release
//   req_pulse  one-cycle request strobe, one bit per requester
//   req_data   requester bytes; slot i = req_data[i*DATA_W +: DATA_W]
//   tx_busy    uart_tx busy flag, high from accept until the stop bit is done
//   tx_start   one-cycle start strobe to uart_tx
//   tx_data    byte to uart_tx; held from tx_start until the next grant
//   grant_id   index of the requester currently or most recently served
//   pending    requester flags that are latched and not yet issued
//   overrun    sticky flags: a pulse arrived while that slot was pending
//   tx_err     one-cycle pulse when tx_busy fails to rise within ACK_TIMEOUT

module uart_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 8,
    parameter int ACK_TIMEOUT = 15,
    localparam int GID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_pulse,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic                      tx_busy,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    output logic [GID_W-1:0]          grant_id,
    output logic [N_REQ-1:0]          pending,
    output logic [N_REQ-1:0]          overrun,
    output logic                      tx_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(ACK_TIMEOUT);

    state_t              state_q;
    logic                tx_start_q;
    logic [DATA_W-1:0]   tx_data_q;
    logic [GID_W-1:0]    grant_q;
    logic [N_REQ-1:0]    pending_q;
    logic [N_REQ-1:0]    pending_d;
    logic [N_REQ-1:0]    overrun_q;
    logic [N_REQ-1:0]    overrun_d;
    logic                tx_err_q;
    logic [7:0]          cnt_q;
    logic [7:0]          cnt_inc;
    logic [N_REQ-1:0]    slot_we;
    logic [DATA_W-1:0]   slot_q [N_REQ];

    logic                pick_valid;
    logic [GID_W-1:0]    pick_idx;
    logic [GID_W-1:0]    cand;

    // Per-requester capture. The slot being issued this cycle (START) is
    // released; a pulse landing in that same cycle re-arms it with new data
    // and is not treated as an overrun.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
        logic clear_now;
        assign clear_now     = (state_q == START) && (grant_q == GID_W'(gi));
        assign pending_d[gi] = req_pulse[gi] | (pending_q[gi] & ~clear_now);
        assign overrun_d[gi] = overrun_q[gi] | (req_pulse[gi] & pending_q[gi] & ~clear_now);
        assign slot_we[gi]   = req_pulse[gi] & (~pending_q[gi] | clear_now);
    end

    // Slot data needs no reset: it is only read after its pending bit is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (slot_we[i]) begin
                slot_q[i] <= req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Round-robin pick: scan grant+1, grant+2, ... wrapping. The loop runs
    // from the farthest offset down so the nearest pending requester wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = grant_q;
        cand       = grant_q;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = GID_W'((int'(grant_q) + k) % N_REQ);
            if (pending_q[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign cnt_inc = cnt_q + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            grant_q    <= GID_W'(N_REQ - 1);
            pending_q  <= '0;
            overrun_q  <= '0;
            tx_err_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            tx_start_q <= 1'b0;
            tx_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        grant_q    <= pick_idx;
                        tx_data_q  <= slot_q[pick_idx];
                        tx_start_q <= 1'b1;
                        state_q    <= START;
                    end
                end
                START: begin
                    cnt_q   <= '0;
                    state_q <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state_q <= WAIT_DONE;
                    end else begin
                        cnt_q <= cnt_inc;
                        // Transmitter never acknowledged: drop the byte.
                        if (cnt_inc == TIMEOUT_LIMIT) begin
                            tx_err_q <= 1'b1;
                            state_q  <= IDLE;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign grant_id = grant_q;
    assign pending  = pending_q;
    assign overrun  = overrun_q;
    assign tx_err   = tx_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple uart_tx busy responder.
module tb_uart_tx_arbiter;

    localparam int BUSY_LEN = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_pulse = 4'b0;
    logic [31:0] req_data = 32'h0;
    logic        tx_busy = 1'b0;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [1:0]  grant_id;
    logic [3:0]  pending;
    logic [3:0]  overrun;
    logic        tx_err;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int pulse_cyc = 0;
    int err_cnt = 0;
    bit busy_en = 1'b1;
    bit start_seen = 1'b0;
    int busy_cnt = 0;

    logic [7:0] dq[$];
    logic [1:0] gq[$];
    int         cq[$];

    uart_tx_arbiter #(.N_REQ(4), .DATA_W(8), .ACK_TIMEOUT(15)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_pulse (req_pulse),
        .req_data  (req_data),
        .tx_busy   (tx_busy),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .grant_id  (grant_id),
        .pending   (pending),
        .overrun   (overrun),
        .tx_err    (tx_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // uart_tx stand-in: busy rises one cycle after tx_start, for BUSY_LEN cycles.
    always @(negedge clk) begin
        if (!rst_n) begin
            start_seen = 1'b0;
            busy_cnt   = 0;
            tx_busy    = 1'b0;
        end else begin
            if (start_seen) begin
                tx_busy    = 1'b1;
                busy_cnt   = BUSY_LEN;
                start_seen = 1'b0;
            end else if (busy_cnt > 0) begin
                busy_cnt = busy_cnt - 1;
                if (busy_cnt == 0) tx_busy = 1'b0;
            end
            if (tx_start && busy_en) start_seen = 1'b1;
        end
    end

    // Transaction monitor.
    always @(negedge clk) begin
        if (tx_start) begin
            dq.push_back(tx_data);
            gq.push_back(grant_id);
            cq.push_back(cyc);
            $display("tx: cyc=%0d grant=%0d data=%02h", cyc, grant_id, tx_data);
        end
        if (tx_err) begin
            err_cnt = err_cnt + 1;
            $display("tx_err: cyc=%0d", cyc);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_pulse = 4'b0;
        busy_en = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse(input logic [3:0] m, input logic [31:0] d);
        @(negedge clk);
        pulse_cyc = cyc;
        req_pulse = m;
        req_data  = d;
        @(negedge clk);
        req_pulse = 4'b0;
    endtask

    task automatic wait_starts(input int target, input int budget);
        for (int i = 0; i < budget && dq.size() < target; i++) @(negedge clk);
        total++;
        if (dq.size() < target) begin
            bad++;
            $display("FAIL wait_starts: got %0d starts, need %0d", dq.size(), target);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({tx_start, tx_data, grant_id, pending, overrun, tx_err} !== {1'b0, 8'h00, 2'd3, 4'h0, 4'h0, 1'b0}) begin
            bad++;
            $display("FAIL reset_vals: got start=%b data=%h gid=%0d pend=%b ovr=%b err=%b", tx_start, tx_data, grant_id, pending, overrun, tx_err);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({tx_start, grant_id, pending} !== {1'b0, 2'd3, 4'h0}) begin
            bad++;
            $display("FAIL reset_idle: got start=%b gid=%0d pend=%b, want 0 3 0000", tx_start, grant_id, pending);
        end
    endtask

    task automatic test_single();
        int n0;
        do_reset();
        n0 = dq.size();
        pulse(4'b0100, {8'h00, 8'h41, 8'h00, 8'h00});
        total++;
        if (pending !== 4'b0100) begin
            bad++;
            $display("FAIL single_pending: got %b want 0100", pending);
        end
        @(negedge clk);
        total++;
        if ({tx_start, tx_data, grant_id} !== {1'b1, 8'h41, 2'd2}) begin
            bad++;
            $display("FAIL single_start: got start=%b data=%h gid=%0d want 1 41 2", tx_start, tx_data, grant_id);
        end
        @(negedge clk);
        total++;
        if ({tx_start, pending} !== {1'b0, 4'b0000}) begin
            bad++;
            $display("FAIL single_after: got start=%b pend=%b want 0 0000", tx_start, pending);
        end
        repeat (15) @(negedge clk);
        total++;
        if (dq.size() != n0 + 1) begin
            bad++;
            $display("FAIL single_count: got %0d starts want 1", dq.size() - n0);
        end else begin
            total++;
            if (cq[n0] != pulse_cyc + 2) begin
                bad++;
                $display("FAIL single_latency: got %0d cycles want 2", cq[n0] - pulse_cyc);
            end
        end
    endtask

    task automatic test_multi();
        int n0;
        do_reset();
        n0 = dq.size();
        pulse(4'b1011, {8'h13, 8'h00, 8'h11, 8'h10});
        wait_starts(n0 + 3, 100);
        repeat (20) @(negedge clk);
        total++;
        if (dq.size() != n0 + 3) begin
            bad++;
            $display("FAIL multi_count: got %0d starts want 3", dq.size() - n0);
        end else begin
            total++;
            if ({gq[n0], gq[n0+1], gq[n0+2]} !== {2'd0, 2'd1, 2'd3}) begin
                bad++;
                $display("FAIL multi_order: got %0d,%0d,%0d want 0,1,3", gq[n0], gq[n0+1], gq[n0+2]);
            end
            total++;
            if ({dq[n0], dq[n0+1], dq[n0+2]} !== {8'h10, 8'h11, 8'h13}) begin
                bad++;
                $display("FAIL multi_data: got %h,%h,%h want 10,11,13", dq[n0], dq[n0+1], dq[n0+2]);
            end
        end
    endtask

    task automatic test_overrun();
        int n0;
        do_reset();
        n0 = dq.size();
        @(negedge clk);
        req_pulse = 4'b0010;
        req_data  = {8'h00, 8'h00, 8'h55, 8'h00};
        @(negedge clk);
        req_data  = {8'h00, 8'h00, 8'h66, 8'h00};
        @(negedge clk);
        req_pulse = 4'b0;
        repeat (25) @(negedge clk);
        total++;
        if (dq.size() != n0 + 1) begin
            bad++;
            $display("FAIL ovr_count: got %0d starts want 1", dq.size() - n0);
        end else begin
            total++;
            if (dq[n0] !== 8'h55) begin
                bad++;
                $display("FAIL ovr_data: got %h want 55", dq[n0]);
            end
        end
        total++;
        if (overrun !== 4'b0010) begin
            bad++;
            $display("FAIL ovr_flag: got %b want 0010", overrun);
        end
        pulse(4'b1000, {8'h99, 8'h00, 8'h00, 8'h00});
        wait_starts(n0 + 2, 40);
        repeat (15) @(negedge clk);
        total++;
        if (overrun !== 4'b0010) begin
            bad++;
            $display("FAIL ovr_sticky: got %b want 0010", overrun);
        end
        if (dq.size() >= n0 + 2) begin
            total++;
            if (dq[n0+1] !== 8'h99) begin
                bad++;
                $display("FAIL ovr_next: got %h want 99", dq[n0+1]);
            end
        end
    endtask

    task automatic test_timeout();
        int n0;
        int e0;
        int err_cyc;
        bit seen;
        do_reset();
        busy_en = 1'b0;
        n0 = dq.size();
        e0 = err_cnt;
        pulse(4'b1000, {8'h33, 8'h00, 8'h00, 8'h00});
        pulse(4'b0001, {8'h00, 8'h00, 8'h00, 8'h44});
        seen = 1'b0;
        err_cyc = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (tx_err) begin
                seen = 1'b1;
                err_cyc = cyc;
            end
        end
        busy_en = 1'b1;
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL to_seen: tx_err never rose within 40 cycles");
        end else begin
            total++;
            if (dq.size() < n0 + 1 || err_cyc - cq[n0] != 16) begin
                bad++;
                $display("FAIL to_delay: got %0d cycles after START want 16", (dq.size() > n0) ? err_cyc - cq[n0] : -1);
            end
            @(negedge clk);
            total++;
            if ({tx_err, tx_start, tx_data, grant_id} !== {1'b0, 1'b1, 8'h44, 2'd0}) begin
                bad++;
                $display("FAIL to_next: got err=%b start=%b data=%h gid=%0d want 0 1 44 0", tx_err, tx_start, tx_data, grant_id);
            end
        end
        repeat (20) @(negedge clk);
        total++;
        if (err_cnt - e0 != 1 || dq.size() != n0 + 2) begin
            bad++;
            $display("FAIL to_counts: got errs=%0d starts=%0d want 1 2", err_cnt - e0, dq.size() - n0);
        end
    endtask

    task automatic test_fairness();
        int n0;
        do_reset();
        n0 = dq.size();
        for (int k = 0; k < 120 && dq.size() < n0 + 3; k++) begin
            @(negedge clk);
            req_pulse = (k == 1) ? 4'b0101 : 4'b0001;
            req_data  = {8'h00, 8'hC2, 8'h00, 8'(8'hA0 + k)};
        end
        @(negedge clk);
        req_pulse = 4'b0;
        total++;
        if (dq.size() < n0 + 3) begin
            bad++;
            $display("FAIL fair_count: got %0d starts want 3", dq.size() - n0);
        end else begin
            total++;
            if ({gq[n0], gq[n0+1], gq[n0+2]} !== {2'd0, 2'd2, 2'd0}) begin
                bad++;
                $display("FAIL fair_order: got %0d,%0d,%0d want 0,2,0", gq[n0], gq[n0+1], gq[n0+2]);
            end
            total++;
            if ({dq[n0], dq[n0+1], dq[n0+2]} !== {8'hA0, 8'hC2, 8'hA2}) begin
                bad++;
                $display("FAIL fair_data: got %h,%h,%h want A0,C2,A2", dq[n0], dq[n0+1], dq[n0+2]);
            end
        end
        total++;
        if (overrun !== 4'b0001) begin
            bad++;
            $display("FAIL fair_overrun: got %b want 0001", overrun);
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        do_reset();
        n0 = dq.size();
        pulse(4'b0100, {8'h00, 8'h77, 8'h00, 8'h00});
        wait_starts(n0 + 1, 20);
        repeat (4) @(negedge clk);
        pulse(4'b0010, {8'h00, 8'h00, 8'h22, 8'h00});
        total++;
        if ({tx_busy, pending, tx_data} !== {1'b1, 4'b0010, 8'h77}) begin
            bad++;
            $display("FAIL mid_pre: got busy=%b pend=%b data=%h want 1 0010 77", tx_busy, pending, tx_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({tx_start, tx_data, grant_id, pending, overrun, tx_err} !== {1'b0, 8'h00, 2'd3, 4'h0, 4'h0, 1'b0}) begin
            bad++;
            $display("FAIL mid_reset: got start=%b data=%h gid=%0d pend=%b ovr=%b err=%b", tx_start, tx_data, grant_id, pending, overrun, tx_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        total++;
        if (dq.size() != n0 + 1 || pending !== 4'b0) begin
            bad++;
            $display("FAIL mid_after: got starts=%0d pend=%b want 1 0000", dq.size() - n0, pending);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_overrun();
        test_timeout();
        test_fairness();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
